// File: rtl/wb_timer.sv
// ============================================================================
// Module   : wb_timer
// Brief    : Wishbone machine timer: prescaled 64-bit mtime, mtimecmp, IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_timer #(
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        timer_interrupt_o
);

  localparam logic [2:0] c_idx_ctrl     = 3'd0;
  localparam logic [2:0] c_idx_prescale = 3'd1;
  localparam logic [2:0] c_idx_mtime_lo = 3'd2;
  localparam logic [2:0] c_idx_mtime_hi = 3'd3;
  localparam logic [2:0] c_idx_cmp_lo   = 3'd4;
  localparam logic [2:0] c_idx_cmp_hi   = 3'd5;

  logic                      r_ctrl_en;
  logic                      r_ctrl_ie;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [31:0]               r_mtime_lo;
  logic [31:0]               r_mtime_hi;
  logic [31:0]               r_shadow;
  logic [63:0]               r_mtimecmp;
  logic                      r_ack;
  logic                      r_err;
  logic [31:0]               r_dat;
  logic                      r_irq;

  logic [2:0]  w_idx;
  logic        w_mapped;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_carry;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_prescale_rd;
  logic [31:0] w_ctrl_new;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_idx    = adr_i[4:2];
  assign w_mapped = (w_idx <= c_idx_cmp_hi);
  // Holding off while a termination is visible keeps a held request from being served twice.
  assign w_accept = cyc_i & stb_i & ~r_ack & ~r_err;
  assign w_wr     = w_accept & we_i & w_mapped;
  assign w_rd     = w_accept & ~we_i & w_mapped;

  assign w_tick  = r_ctrl_en & (r_pcnt == r_prescale);
  assign w_carry = w_tick & (r_mtime_lo == 32'hFFFF_FFFF);

  assign w_ctrl_rd     = {30'h0, r_ctrl_ie, r_ctrl_en};
  assign w_prescale_rd = 32'(r_prescale);
  assign w_ctrl_new    = f_merge(w_ctrl_rd, dat_i, sel_i);
  assign w_unused      = ^{adr_i[31:5], adr_i[1:0], w_ctrl_new[31:2]};

  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      c_idx_ctrl:     w_rdata = w_ctrl_rd;
      c_idx_prescale: w_rdata = w_prescale_rd;
      c_idx_mtime_lo: w_rdata = r_mtime_lo;
      c_idx_mtime_hi: w_rdata = r_shadow;
      c_idx_cmp_lo:   w_rdata = r_mtimecmp[31:0];
      c_idx_cmp_hi:   w_rdata = r_mtimecmp[63:32];
      default:        w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_accept & w_mapped;
      r_err <= w_accept & ~w_mapped;
      r_dat <= w_rd ? w_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl_en  <= 1'b0;
      r_ctrl_ie  <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_mtimecmp <= MTIMECMP_RESET;
      r_shadow   <= 32'h0;
    end else begin
      if (w_wr && w_idx == c_idx_ctrl) begin
        r_ctrl_en <= w_ctrl_new[0];
        r_ctrl_ie <= w_ctrl_new[1];
      end
      if (w_wr && w_idx == c_idx_prescale) begin
        r_prescale <= PRESCALE_WIDTH'(f_merge(w_prescale_rd, dat_i, sel_i));
      end
      if (!r_ctrl_en || w_tick || (w_wr && w_idx == c_idx_prescale)) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
      if (w_wr && w_idx == c_idx_cmp_lo) begin
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], dat_i, sel_i);
      end
      if (w_wr && w_idx == c_idx_cmp_hi) begin
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], dat_i, sel_i);
      end
      // Freeze the upper half so a following HI read is coherent with this LO read.
      if (w_rd && w_idx == c_idx_mtime_lo) begin
        r_shadow <= r_mtime_hi;
      end
    end
  end

  // A bus write to either half wins over the tick for that half only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime_lo <= 32'h0;
      r_mtime_hi <= 32'h0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && w_idx == c_idx_mtime_lo) begin
        r_mtime_lo <= f_merge(r_mtime_lo, dat_i, sel_i);
      end else if (w_tick) begin
        r_mtime_lo <= r_mtime_lo + 32'h1;
      end
      if (w_wr && w_idx == c_idx_mtime_hi) begin
        r_mtime_hi <= f_merge(r_mtime_hi, dat_i, sel_i);
      end else if (w_carry) begin
        r_mtime_hi <= r_mtime_hi + 32'h1;
      end
      r_irq <= r_ctrl_ie & ({r_mtime_hi, r_mtime_lo} >= r_mtimecmp);
    end
  end

  assign dat_o             = r_dat;
  assign ack_o             = r_ack;
  assign err_o             = r_err;
  assign timer_interrupt_o = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_timer.sv
// ============================================================================
// Module   : tb_wb_timer
// Brief    : Self-checking bench for wb_timer against a tick-arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_timer;

  localparam logic [63:0] c_cmp_reset = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] adr_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        timer_interrupt_o;

  wb_timer #(
    .PRESCALE_WIDTH(16),
    .MTIMECMP_RESET(c_cmp_reset)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cyc_i            (cyc_i),
    .stb_i            (stb_i),
    .we_i             (we_i),
    .adr_i            (adr_i),
    .sel_i            (sel_i),
    .dat_i            (dat_i),
    .dat_o            (dat_o),
    .ack_o            (ack_o),
    .err_o            (err_o),
    .timer_interrupt_o(timer_interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] n_edge = 64'd0;
  always @(posedge clk_i) n_edge <= n_edge + 64'd1;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: mtime is a base value plus whole prescale periods elapsed since t0.
  logic        m_en, m_ie;
  logic [63:0] m_base, m_p, m_cmp, m_t0, m_ph;
  logic [31:0] m_shadow;

  function automatic logic [63:0] mt_after(input logic [63:0] e);
    if (!m_en) return m_base;
    return m_base + (e - m_t0 + m_ph) / (m_p + 64'd1);
  endfunction

  function automatic logic [63:0] cnt_after(input logic [63:0] e);
    if (!m_en) return 64'd0;
    return (e - m_t0 + m_ph) % (m_p + 64'd1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_ie = 1'b0; m_base = 64'd0; m_p = 64'd0;
    m_cmp = c_cmp_reset; m_t0 = n_edge; m_ph = 64'd0; m_shadow = 32'h0;
  endtask

  // Applies an access accepted at edge e; returns the value a read should see.
  task automatic model_access(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                              input logic [31:0] wd, input logic [63:0] e,
                              output logic [31:0] exp_rd);
    logic [63:0] prev, cur, cnt;
    logic [31:0] nv;
    prev = mt_after(e - 64'd1);
    cur  = mt_after(e);
    cnt  = cnt_after(e);
    exp_rd = 32'h0;
    if (idx > 3'd5) return;
    if (!we) begin
      case (idx)
        3'd0: exp_rd = {30'h0, m_ie, m_en};
        3'd1: exp_rd = m_p[31:0];
        3'd2: begin exp_rd = prev[31:0]; m_shadow = prev[63:32]; end
        3'd3: exp_rd = m_shadow;
        3'd4: exp_rd = m_cmp[31:0];
        default: exp_rd = m_cmp[63:32];
      endcase
    end else begin
      case (idx)
        3'd0: begin
          nv = merge({30'h0, m_ie, m_en}, wd, sel);
          m_base = cur; m_t0 = e; m_ph = cnt; m_en = nv[0]; m_ie = nv[1];
        end
        3'd1: begin
          nv = merge(m_p[31:0], wd, sel);
          m_base = cur; m_t0 = e; m_ph = 64'd0; m_p = {48'h0, nv[15:0]};
        end
        3'd2: begin
          m_base = {cur[63:32], merge(prev[31:0], wd, sel)}; m_t0 = e; m_ph = cnt;
        end
        3'd3: begin
          m_base = {merge(prev[63:32], wd, sel), cur[31:0]}; m_t0 = e; m_ph = cnt;
        end
        3'd4: m_cmp[31:0] = merge(m_cmp[31:0], wd, sel);
        default: m_cmp[63:32] = merge(m_cmp[63:32], wd, sel);
      endcase
    end
  endtask

  function automatic logic exp_irq();
    return m_ie && (mt_after(n_edge - 64'd1) >= m_cmp);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ok(input string name, input logic ok, input logic [63:0] act);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, outside the allowed set", name, act);
    end
  endtask

  // One single-beat transfer; returns sampled termination and model expectation.
  task automatic bus(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                     input logic [31:0] wd, output logic [31:0] rd, output logic ack,
                     output logic err, output logic irq, output logic [31:0] exp_rd);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = idx;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; sel_i = sel; dat_i = wd;
    @(posedge clk_i); #1;
    rd = dat_o; ack = ack_o; err = err_o; irq = timer_interrupt_o;
    model_access(we, idx, sel, wd, n_edge, exp_rd);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] rd, ex;
    logic ack, err, irq;
    bus(1'b1, idx, 4'hF, wd, rd, ack, err, irq, ex);
    check("write_ack", {63'h0, ack}, 64'd1);
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [31:0] rd, output logic [31:0] ex);
    logic ack, err, irq;
    bus(1'b0, idx, 4'hF, 32'h0, rd, ack, err, irq, ex);
    check("read_ack", {63'h0, ack}, 64'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[21];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd, ex, rd2, ex2;
    logic ack, err, irq;
    logic rose;

    vecs[0]  = '{1'b0, 3'd0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 3'd2, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 3'd3, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 3'd4, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 3'd5, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 3'd1, 4'hF, 32'h3,         1'b1, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h3};
    vecs[8]  = '{1'b1, 3'd1, 4'hF, 32'hFFFF_1234, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234};
    vecs[10] = '{1'b1, 3'd4, 4'h4, 32'h00AB_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd4, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFAB_FFFF};
    vecs[12] = '{1'b0, 3'd6, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 3'd7, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 3'd0, 4'hF, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'd0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[16] = '{1'b1, 3'd0, 4'h1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'd0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h2};
    vecs[18] = '{1'b1, 3'd0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 3'd1, 4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", {63'h0, ack_o}, 64'd0);
    check("rst_err", {63'h0, err_o}, 64'd0);
    check("rst_dat", {32'h0, dat_o}, 64'd0);
    check("rst_irq", {63'h0, timer_interrupt_o}, 64'd0);
    rst_ni = 1'b1;
    model_reset();

    // Register map table
    for (int i = 0; i < 21; i++) begin
      bus(vecs[i].we, vecs[i].idx, vecs[i].sel, vecs[i].wd, rd, ack, err, irq, ex);
      check($sformatf("vec%0d_ack", i), {63'h0, ack}, {63'h0, vecs[i].exp_ack});
      check($sformatf("vec%0d_err", i), {63'h0, err}, {63'h0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_dat", i), {32'h0, rd}, {32'h0, vecs[i].exp_rd});
    end

    // Held request: terminated, released for a cycle, then served again
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0; sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("held_ack%0d", i), {63'h0, ack_o}, {63'h0, ((i % 2) == 0)});
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;

    // Prescaled count, then frozen
    wr(3'd0, 32'h0); wr(3'd2, 32'h0); wr(3'd3, 32'h0); wr(3'd1, 32'h3); wr(3'd0, 32'h1);
    repeat (40) @(posedge clk_i);
    #1;
    rd_reg(3'd2, rd, ex);
    check_ok("presc_count_range", rd >= 32'd9 && rd <= 32'd11, {32'h0, rd});
    check("presc_count_model", {32'h0, rd}, {32'h0, ex});
    wr(3'd0, 32'h0);
    rd_reg(3'd2, rd, ex);
    repeat (20) @(posedge clk_i);
    #1;
    rd_reg(3'd2, rd2, ex2);
    check("frozen_a", {32'h0, rd}, {32'h0, ex});
    check("frozen_b", {32'h0, rd2}, {32'h0, ex2});

    // Atomic read across the low-word wrap
    wr(3'd2, 32'hFFFF_FFFE); wr(3'd3, 32'h0); wr(3'd1, 32'h0); wr(3'd0, 32'h1);
    rd_reg(3'd2, rd, ex);
    rd_reg(3'd3, rd2, ex2);
    check_ok("atomic_lo", rd == 32'hFFFF_FFFF || rd == 32'hFFFF_FFFE, {32'h0, rd});
    check("atomic_lo_model", {32'h0, rd}, {32'h0, ex});
    check("atomic_hi_shadow", {32'h0, rd2}, 64'd0);
    rd_reg(3'd2, rd, ex);
    rd_reg(3'd3, rd2, ex2);
    check("atomic_hi_after", {32'h0, rd2}, 64'd1);

    // Interrupt rise at mtime=20 and fall after mtimecmp is raised
    wr(3'd0, 32'h0); wr(3'd2, 32'h0); wr(3'd3, 32'h0); wr(3'd1, 32'h0);
    wr(3'd5, 32'h0); wr(3'd4, 32'd20); wr(3'd0, 32'h3);
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("irq_track", {63'h0, timer_interrupt_o}, {63'h0, exp_irq()});
      if (timer_interrupt_o && !rose) begin
        rose = 1'b1;
        check("irq_rise_mtime", mt_after(n_edge - 64'd1), 64'd20);
      end
      @(posedge clk_i); #1;
    end
    check("irq_rose", {63'h0, rose}, 64'd1);
    bus(1'b1, 3'd4, 4'hF, 32'd1000, rd, ack, err, irq, ex);
    check("irq_at_cmp_write", {63'h0, irq}, 64'd1);
    check("irq_after_cmp_write", {63'h0, timer_interrupt_o}, 64'd0);

    // Randomized traffic against the model
    wr(3'd1, 32'h0);
    for (int i = 0; i < 250; i++) begin
      logic [2:0]  idx;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wd;
      idx = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      case (idx)
        3'd1:    wd = 32'($urandom_range(0, 5));
        3'd3:    wd = 32'($urandom_range(0, 2));
        3'd4:    wd = 32'($urandom_range(0, 300));
        3'd5:    wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        default: wd = $urandom;
      endcase
      bus(we, idx, sel, wd, rd, ack, err, irq, ex);
      check("rnd_ack", {63'h0, ack}, {63'h0, (idx <= 3'd5)});
      check("rnd_err", {63'h0, err}, {63'h0, (idx > 3'd5)});
      if (!we || idx > 3'd5) check($sformatf("rnd_dat_idx%0d", idx), {32'h0, rd}, {32'h0, ex});
      repeat ($urandom_range(0, 4)) @(posedge clk_i);
      #1;
      check("rnd_irq", {63'h0, timer_interrupt_o}, {63'h0, exp_irq()});
    end

    // Asynchronous reset during an acknowledge with the interrupt high
    wr(3'd0, 32'h0); wr(3'd5, 32'h0); wr(3'd4, 32'h0); wr(3'd1, 32'h0); wr(3'd0, 32'h3);
    check("pre_rst_irq", {63'h0, timer_interrupt_o}, 64'd1);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h4;
    @(posedge clk_i); #1;
    check("pre_rst_ack", {63'h0, ack_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check("async_rst_ack", {63'h0, ack_o}, 64'd0);
    check("async_rst_irq", {63'h0, timer_interrupt_o}, 64'd0);
    model_reset();
    we_i = 1'b1; adr_i = 32'h4; sel_i = 4'hF; dat_i = 32'h5;
    @(posedge clk_i); #1;
    check("rst_abort_ack", {63'h0, ack_o}, 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    rst_ni = 1'b1;
    rd_reg(3'd2, rd, ex);
    check("post_rst_mtime", {32'h0, rd}, 64'd0);
    rd_reg(3'd4, rd, ex);
    check("post_rst_cmp_lo", {32'h0, rd}, 64'hFFFF_FFFF);
    rd_reg(3'd1, rd, ex);
    check("post_rst_prescale", {32'h0, rd}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
